branch_history_predictor: RTL and testbench
===========================================

# branch_history_predictor

Parametrised branch direction predictor: a table of 2^IDX_W saturating counters of CTR_W bits, indexed by low PC bits, optionally hashed with a global taken/not-taken history (gshare). Sits beside the fetch stage. Fetch issues a lookup and receives a registered prediction plus the index used. The execute stage later returns that index together with the resolved outcome to train the table and count mispredictions.

## Interface
Parameters:
- IDX_W, 6: table index width; depth = 2^IDX_W entries.
- CTR_W, 2: counter width, minimum 2.
- HIST_W, 6: global history length, must be ≤ IDX_W; used only with GSHARE_EN.
- STAT_W, 16: mispredict counter width.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  lookup request.
- req_pc  in  IDX_W  branch PC bits used for indexing.
- pred_valid  out  1  prediction valid, one cycle after req_valid.
- pred_taken  out  1  predicted direction.
- pred_idx  out  IDX_W  table index used; carried down the pipeline.
- upd_valid  in  1  resolved branch update.
- upd_idx  in  IDX_W  index returned from pred_idx.
- upd_taken  in  1  actual outcome.
- upd_pred  in  1  direction that was predicted for this branch.
- mispred_cnt  out  STAT_W  saturating count of updates with upd_taken != upd_pred.

## Operation
- Reset:
  - Every counter is set to weakly taken: MSB=1, other bits 0 (2'b10 for CTR_W=2).
  - History is cleared to 0.
  - pred_valid=0, pred_taken=0, pred_idx=0, mispred_cnt=0.
- Lookup:
  - Index = req_pc, or req_pc XOR zero-extended history with GSHARE_EN.
  - pred_taken = MSB of the indexed counter.
  - pred_idx = index.
  - pred_valid = req_valid, registered.
  - With req_valid=0, pred_valid=0 and pred_taken/pred_idx hold their last values.
- Update (upd_valid=1):
  - Counter[upd_idx] increments on taken, saturating at 2^CTR_W-1.
  - Counter[upd_idx] decrements on not-taken, saturating at 0.
  - No wrap-around in either direction.
  - History shifts left by one with upd_taken entering at bit 0; oldest bit is dropped.
- mispred_cnt increments when upd_valid and upd_taken != upd_pred. It saturates at all-ones and never wraps.
- Simultaneous lookup and update:
  - Both occur in the same cycle.
  - The lookup reads the pre-update counter value (no bypass).
  - The lookup hashes with the pre-update history.
  - A same-index collision is legal and follows the same rule.
- upd_idx must be a value previously produced on pred_idx. The block does not check this; any in-range index trains that entry.
- Reset asserted mid-operation discards in-flight predictions immediately, since outputs clear asynchronously. Updates presented while rst_n=0 are ignored.

## Timing
- Lookup latency: 1 cycle. req_valid at edge N gives pred_valid/pred_taken/pred_idx visible after edge N+1.
- Update takes effect at the edge where upd_valid=1. A lookup in the following cycle sees the new counter and history.
- mispred_cnt is registered and reflects an update one edge after it is presented.
- Full throughput: one lookup and one update per cycle. No stalls, no backpressure.

## Configuration
- GSHARE_EN defined:
  - History register of HIST_W bits exists.
  - Lookup index = req_pc XOR history.
- GSHARE_EN undefined:
  - Pure bimodal: index = req_pc.
  - No history register; HIST_W is ignored.
  - All other behaviour is identical.

## Structure
- Package bp_pkg holds:
  - Counter init constant (MSB set).
  - Saturation limit functions of CTR_W.
  - Index typedef sized by IDX_W.
- Sub-module bp_sat_update: combinational next-state of one counter (inputs: counter, taken; output: saturated next value). Instantiated once on the update path.
- The table is a flop array in the top module, not SRAM, so that asynchronous reset initialises it.

## Test plan
- Reset, then lookup pc=5 → after 1 cycle pred_valid=1, pred_taken=1, pred_idx=5 (bimodal).
- 3 not-taken updates to idx 5 → counter saturates at 0, lookup pc=5 gives pred_taken=0; one more not-taken leaves it at 0.
- 4 taken updates to idx 9 with CTR_W=2 → counter holds at 3; one not-taken → 2, prediction still 1.
- Same cycle: lookup pc=7 and not-taken update idx 7 from 2 → pred_taken=1 (old value); next lookup pc=7 gives 0.
- GSHARE_EN, HIST_W=6: updates taken, taken, not-taken → history=6'b000110; lookup pc=6'b000011 → pred_idx=6'b000101.
- 2^STAT_W+3 updates with upd_taken != upd_pred (reduced STAT_W=4) → mispred_cnt holds at 15; assert rst_n=0 mid-run → mispred_cnt=0 and pred_valid=0 immediately.

Source files
------------

// File: rtl/bp_pkg.sv
// bp_pkg -- shared definitions for the branch direction predictor.
//
// Contents:
//   BP_IDX_W / bp_idx_t : default table index width and index type
//   BP_CTR_W / BP_CTR_INIT : default counter width and "weakly taken" init value
//   ctr_max()  : saturation ceiling of a counter of a given width (all ones)
//   ctr_init() : weakly-taken value of a counter of a given width (MSB set only)
package bp_pkg;

  localparam int unsigned BP_IDX_W = 6;
  typedef logic [BP_IDX_W-1:0] bp_idx_t;

  localparam int unsigned BP_CTR_W = 2;

  // Largest value a ctr_w-bit counter may hold; increments stop here.
  function automatic int unsigned ctr_max(input int unsigned ctr_w);
    return (32'd1 << ctr_w) - 32'd1;
  endfunction

  // Weakly taken: only the MSB set, so a single not-taken flips the prediction.
  function automatic int unsigned ctr_init(input int unsigned ctr_w);
    return 32'd1 << (ctr_w - 32'd1);
  endfunction

  localparam logic [BP_CTR_W-1:0] BP_CTR_INIT = BP_CTR_W'(ctr_init(BP_CTR_W));

endpackage

// File: rtl/bp_sat_update.sv
// bp_sat_update -- combinational next state of one saturating counter.
//
// Ports:
//   ctr_i   in  CTR_W  current counter value
//   taken_i in  1      resolved outcome (1 = count up, 0 = count down)
//   ctr_o   out CTR_W  next value, clamped to [0, 2^CTR_W-1] (never wraps)
module bp_sat_update
  import bp_pkg::*;
#(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] ctr_i,
  input  logic             taken_i,
  output logic [CTR_W-1:0] ctr_o
);

  localparam logic [CTR_W-1:0] CTR_MAX = CTR_W'(ctr_max(CTR_W));
  localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(1);

  always_comb begin
    ctr_o = ctr_i;
    if (taken_i) begin
      if (ctr_i != CTR_MAX) begin
        ctr_o = ctr_i + CTR_ONE;
      end
    end else begin
      if (ctr_i != '0) begin
        ctr_o = ctr_i - CTR_ONE;
      end
    end
  end

endmodule

// File: rtl/branch_history_predictor.sv
// branch_history_predictor -- table of saturating counters predicting branch
// direction, indexed by PC bits (bimodal) or PC XOR global history (gshare).
//
// Build option: define GSHARE_EN to add the HIST_W-bit global history register
// and hash it into the lookup index. Without it the predictor is bimodal and
// HIST_W has no effect on the hardware.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   req_valid, req_pc             lookup request from fetch
//   pred_valid, pred_taken, pred_idx  registered prediction (1-cycle latency);
//                                 taken/idx hold when no lookup is issued
//   upd_valid, upd_idx, upd_taken, upd_pred  training from execute
//   mispred_cnt                   saturating count of mispredicted updates
module branch_history_predictor
  import bp_pkg::*;
#(
  parameter int IDX_W  = 6,
  parameter int CTR_W  = 2,
  parameter int HIST_W = 6,
  parameter int STAT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [IDX_W-1:0]  req_pc,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [IDX_W-1:0]  pred_idx,
  input  logic              upd_valid,
  input  logic [IDX_W-1:0]  upd_idx,
  input  logic              upd_taken,
  input  logic              upd_pred,
  output logic [STAT_W-1:0] mispred_cnt
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(ctr_init(CTR_W));

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CTR_W-1:0] ctr_t;

  // Elaboration-time parameter sanity.
  if (CTR_W < 2) begin : g_bad_ctr_w
    $error("branch_history_predictor: CTR_W must be at least 2");
  end
  if (HIST_W < 1 || HIST_W > IDX_W) begin : g_bad_hist_w
    $error("branch_history_predictor: HIST_W must be in 1..IDX_W");
  end

  // ---------------------------------------------------------------------------
  // Counter table: one flop group per entry so the async reset can initialise
  // every counter to weakly taken.
  // ---------------------------------------------------------------------------
  ctr_t             table_rd [DEPTH];
  logic [DEPTH-1:0] msb_vec;
  ctr_t             upd_ctr;
  ctr_t             upd_ctr_next;

  assign upd_ctr = table_rd[upd_idx];

  bp_sat_update #(
    .CTR_W (CTR_W)
  ) u_sat_update (
    .ctr_i   (upd_ctr),
    .taken_i (upd_taken),
    .ctr_o   (upd_ctr_next)
  );

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    ctr_t ctr_q;
    ctr_t ctr_d;

    always_comb begin
      ctr_d = ctr_q;
      if (upd_valid && (upd_idx == idx_t'(gi))) begin
        ctr_d = upd_ctr_next;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ctr_q <= CTR_INIT;
      end else begin
        ctr_q <= ctr_d;
      end
    end

    assign table_rd[gi] = ctr_q;
    assign msb_vec[gi]  = ctr_q[CTR_W-1];
  end

  // ---------------------------------------------------------------------------
  // Lookup index. The lookup uses the history as it stands before any update
  // presented in the same cycle.
  // ---------------------------------------------------------------------------
  idx_t lookup_idx;

`ifdef GSHARE_EN
  logic [HIST_W-1:0] hist_q;
  logic [HIST_W-1:0] hist_d;

  always_comb begin
    hist_d = hist_q;
    if (upd_valid) begin
      // Shift left, newest outcome in bit 0; the cast drops the oldest bit.
      hist_d = HIST_W'({hist_q, upd_taken});
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign lookup_idx = req_pc ^ idx_t'(hist_q);
`else
  assign lookup_idx = req_pc;
`endif

  // ---------------------------------------------------------------------------
  // Prediction registers. Table read is pre-update (no bypass), so a same-cycle
  // update to the looked-up entry is only visible to the next lookup.
  // ---------------------------------------------------------------------------
  logic pred_valid_q, pred_valid_d;
  logic pred_taken_q, pred_taken_d;
  idx_t pred_idx_q,   pred_idx_d;

  always_comb begin
    pred_valid_d = req_valid;
    pred_taken_d = pred_taken_q;
    pred_idx_d   = pred_idx_q;
    if (req_valid) begin
      pred_taken_d = msb_vec[lookup_idx];
      pred_idx_d   = lookup_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pred_valid_q <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_idx_q   <= '0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_taken_q <= pred_taken_d;
      pred_idx_q   <= pred_idx_d;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_taken = pred_taken_q;
  assign pred_idx   = pred_idx_q;

  // ---------------------------------------------------------------------------
  // Mispredict statistics, saturating at all ones.
  // ---------------------------------------------------------------------------
  logic [STAT_W-1:0] mispred_q, mispred_d;

  always_comb begin
    mispred_d = mispred_q;
    if (upd_valid && (upd_taken != upd_pred) && (mispred_q != '1)) begin
      mispred_d = mispred_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispred_q <= '0;
    end else begin
      mispred_q <= mispred_d;
    end
  end

  assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_branch_history_predictor.sv
// tb_branch_history_predictor -- self-checking bench for branch_history_predictor.
// Expected predictions are computed from a behavioural counter/history model
// when a lookup is driven, queued, and compared when the DUT presents them.
// Runs bimodal by default; define GSHARE_EN to exercise the hashed index.
module tb_branch_history_predictor;

  localparam int IDX_W  = 6;
  localparam int CTR_W  = 2;
  localparam int HIST_W = 6;
  localparam int STAT_W = 4;
  localparam int DEPTH  = 1 << IDX_W;
  localparam int CMAX   = (1 << CTR_W) - 1;
  localparam int SMAX   = (1 << STAT_W) - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic [IDX_W-1:0]  req_pc = '0;
  logic              pred_valid;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic              upd_valid = 1'b0;
  logic [IDX_W-1:0]  upd_idx = '0;
  logic              upd_taken = 1'b0;
  logic              upd_pred = 1'b0;
  logic [STAT_W-1:0] mispred_cnt;

  branch_history_predictor #(
    .IDX_W  (IDX_W),
    .CTR_W  (CTR_W),
    .HIST_W (HIST_W),
    .STAT_W (STAT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_pc      (req_pc),
    .pred_valid  (pred_valid),
    .pred_taken  (pred_taken),
    .pred_idx    (pred_idx),
    .upd_valid   (upd_valid),
    .upd_idx     (upd_idx),
    .upd_taken   (upd_taken),
    .upd_pred    (upd_pred),
    .mispred_cnt (mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             taken;
    logic [IDX_W-1:0] idx;
  } exp_t;

  exp_t exp_q[$];

  int               ctr_m [DEPTH];
  logic [HIST_W-1:0] hist_m;
  int               mis_m;
  logic             last_taken;
  logic [IDX_W-1:0] last_idx;
  int               n_checks = 0;
  int               n_fail = 0;
  int               txn = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) ctr_m[i] = 1 << (CTR_W - 1);
    hist_m     = '0;
    mis_m      = 0;
    last_taken = 1'b0;
    last_idx   = '0;
    exp_q.delete();
  endtask

  // Drive one cycle of stimulus, update the model, then check at posedge+1.
  task automatic drive(input logic rv, input logic [IDX_W-1:0] pc, input logic uv,
                       input logic [IDX_W-1:0] ui, input logic ut, input logic up);
    exp_t e;
    logic [IDX_W-1:0] idx;
    req_valid = rv;
    req_pc    = pc;
    upd_valid = uv;
    upd_idx   = ui;
    upd_taken = ut;
    upd_pred  = up;
    if (rv) begin
`ifdef GSHARE_EN
      idx = pc ^ IDX_W'(hist_m);
`else
      idx = pc;
`endif
      e.taken = (ctr_m[idx] >= (1 << (CTR_W - 1)));
      e.idx   = idx;
      exp_q.push_back(e);
    end
    if (uv) begin
      if (ut && ctr_m[ui] < CMAX) ctr_m[ui]++;
      else if (!ut && ctr_m[ui] > 0) ctr_m[ui]--;
      hist_m = {hist_m[HIST_W-2:0], ut};
      if (ut != up && mis_m < SMAX) mis_m++;
    end
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d: req=%0b pc=%0d upd=%0b idx=%0d t=%0b p=%0b -> pv=%0b pt=%0b pi=%0d mis=%0d",
             txn, rv, pc, uv, ui, ut, up, pred_valid, pred_taken, pred_idx, mispred_cnt);
    if (rv) begin
      check_eq("pred_valid", 32'(pred_valid), 32'd1);
      if (exp_q.size() == 0) begin
        check_eq("sb_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("pred_taken", 32'(pred_taken), 32'(e.taken));
        check_eq("pred_idx", 32'(pred_idx), 32'(e.idx));
        last_taken = e.taken;
        last_idx   = e.idx;
      end
    end else begin
      check_eq("pred_valid_idle", 32'(pred_valid), 32'd0);
      check_eq("pred_taken_hold", 32'(pred_taken), 32'(last_taken));
      check_eq("pred_idx_hold", 32'(pred_idx), 32'(last_idx));
    end
    check_eq("mispred_cnt", 32'(mispred_cnt), 32'(mis_m));
  endtask

  initial begin
    model_reset();
    // Reset state
    #12;
    check_eq("rst_pred_valid", 32'(pred_valid), 32'd0);
    check_eq("rst_pred_taken", 32'(pred_taken), 32'd0);
    check_eq("rst_pred_idx", 32'(pred_idx), 32'd0);
    check_eq("rst_mispred", 32'(mispred_cnt), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifndef GSHARE_EN
    // Fresh lookup: weakly taken
    drive(1, 6'd5, 0, 0, 0, 0);
    check_eq("init_taken_pc5", 32'(pred_taken), 32'd1);
    check_eq("init_idx_pc5", 32'(pred_idx), 32'd5);
    // Saturate idx 5 at 0
    for (int i = 0; i < 3; i++) drive(0, 0, 1, 6'd5, 0, 1);
    drive(1, 6'd5, 0, 0, 0, 0);
    check_eq("nt_sat_pc5", 32'(pred_taken), 32'd0);
    drive(0, 0, 1, 6'd5, 0, 0);
    drive(0, 0, 1, 6'd5, 1, 0);
    drive(1, 6'd5, 0, 0, 0, 0);
    check_eq("no_wrap_low_pc5", 32'(pred_taken), 32'd0);
    // Saturate idx 9 at max
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 6'd9, 1, 1);
    drive(0, 0, 1, 6'd9, 0, 1);
    drive(1, 6'd9, 0, 0, 0, 0);
    check_eq("t_sat_pc9", 32'(pred_taken), 32'd1);
    drive(0, 0, 1, 6'd9, 0, 1);
    drive(1, 6'd9, 0, 0, 0, 0);
    check_eq("dec_pc9", 32'(pred_taken), 32'd0);
    // Same-cycle lookup and update on the same entry
    drive(1, 6'd7, 1, 6'd7, 0, 1);
    check_eq("collide_old_pc7", 32'(pred_taken), 32'd1);
    drive(1, 6'd7, 0, 0, 0, 0);
    check_eq("collide_new_pc7", 32'(pred_taken), 32'd0);
`endif

    // Mixed random traffic
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, DEPTH - 1)),
            1'($urandom_range(0, 1)), IDX_W'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Mispredict counter saturation
    for (int i = 0; i < SMAX + 4; i++) drive(0, 0, 1, 6'd20, i[0], ~i[0]);
    check_eq("mispred_sat", 32'(mispred_cnt), 32'(SMAX));

    // Reset mid-run with a prediction in flight
    drive(1, 6'd9, 1, 6'd3, 1, 0);
    rst_n     = 1'b0;
    req_valid = 1'b1;
    upd_valid = 1'b1;
    upd_idx   = 6'd9;
    upd_taken = 1'b0;
    upd_pred  = 1'b1;
    #1;
    check_eq("midrst_pred_valid", 32'(pred_valid), 32'd0);
    check_eq("midrst_mispred", 32'(mispred_cnt), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    upd_valid = 1'b0;
    model_reset();
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 6'd9, 0, 0, 0, 0);
    check_eq("post_rst_pc9", 32'(pred_taken), 32'd1);

    // History: taken, taken, not-taken, then lookup pc=3
    drive(0, 0, 1, 6'd0, 1, 1);
    drive(0, 0, 1, 6'd0, 1, 1);
    drive(0, 0, 1, 6'd0, 0, 0);
    drive(1, 6'd3, 0, 0, 0, 0);
`ifdef GSHARE_EN
    check_eq("gshare_idx", 32'(pred_idx), 32'd5);
`else
    check_eq("bimodal_idx", 32'(pred_idx), 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
